// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared state encoding and default sizes for the ring-oscillator measurement block
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } ro_state_e;

  localparam int RO_GATE_W        = 16;
  localparam int RO_CNT_W         = 16;
  localparam int RO_SETTLE_CYCLES = 4;
  localparam int RO_SYNC_STAGES   = 2;

endpackage

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - multi-flop synchronizer for the oscillator output with rising-edge pulse
module ro_edge_sync
  import ro_pkg::*;
#(
  parameter int SYNC_STAGES = RO_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - ring-oscillator settle/gate/count sequencer with valid/ready result
// Optional RO_MEAS_CTRL_STUCK_EN adds result_stuck (final count of zero).
module ro_meas_ctrl
  import ro_pkg::*;
#(
  parameter int GATE_W        = RO_GATE_W,
  parameter int CNT_W         = RO_CNT_W,
  parameter int SETTLE_CYCLES = RO_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = RO_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              abort,
  input  logic              ro_in,
  output logic              ro_activate,
  output logic              busy,
  output logic [CNT_W-1:0]  result_count,
  output logic              result_sat,
  output logic              result_valid,
  input  logic              result_ready
`ifdef RO_MEAS_CTRL_STUCK_EN
  ,
  output logic              result_stuck
`endif
);

  // One down-counter serves both the settle interval and the gate window.
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  ro_state_e         state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
  logic              sat_q, sat_d, sat_nx;
  logic              ro_activate_q, ro_activate_d;
  logic              busy_q, busy_d;
  logic              result_valid_q, result_valid_d;
  logic [CNT_W-1:0]  result_count_q, result_count_d;
  logic              result_sat_q, result_sat_d;
  logic              stuck_q, stuck_d;
  logic              ro_edge;

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ro_in),
    .edge_pulse (ro_edge)
  );

  always_comb begin
    cnt_nx = cnt_q;
    sat_nx = sat_q;
    if (ro_edge) begin
      if (cnt_q == CNT_MAX) sat_nx = 1'b1;
      else                  cnt_nx = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    gate_d         = gate_q;
    timer_d        = timer_q;
    cnt_d          = cnt_q;
    sat_d          = sat_q;
    ro_activate_d  = ro_activate_q;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    result_count_d = result_count_q;
    result_sat_d   = result_sat_q;
    stuck_d        = stuck_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = SETTLE;
          gate_d        = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
          timer_d       = SETTLE_LOAD;
          cnt_d         = '0;
          sat_d         = 1'b0;
          ro_activate_d = 1'b1;
          busy_d        = 1'b1;
          stuck_d       = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d       = IDLE;
          ro_activate_d = 1'b0;
          busy_d        = 1'b0;
        end else if (timer_q == '0) begin
          state_d = MEASURE;
          timer_d = TMR_W'(gate_q) - 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_d       = IDLE;
          ro_activate_d = 1'b0;
          busy_d        = 1'b0;
        end else begin
          cnt_d = cnt_nx;
          sat_d = sat_nx;
          // The final window cycle still counts, so publish the post-edge value.
          if (timer_q == '0) begin
            state_d        = DONE;
            ro_activate_d  = 1'b0;
            result_valid_d = 1'b1;
            result_count_d = cnt_nx;
            result_sat_d   = sat_nx;
            stuck_d        = (cnt_nx == '0);
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      DONE: begin
        if (result_valid_q && result_ready) begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
          busy_d         = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      gate_q         <= '0;
      timer_q        <= '0;
      cnt_q          <= '0;
      sat_q          <= 1'b0;
      ro_activate_q  <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_count_q <= '0;
      result_sat_q   <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      gate_q         <= gate_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      sat_q          <= sat_d;
      ro_activate_q  <= ro_activate_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_count_q <= result_count_d;
      result_sat_q   <= result_sat_d;
      stuck_q        <= stuck_d;
    end
  end

  assign ro_activate  = ro_activate_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_count = result_count_q;
  assign result_sat   = result_sat_q;

`ifdef RO_MEAS_CTRL_STUCK_EN
  assign result_stuck = stuck_q;
`else
  logic unused_stuck;
  assign unused_stuck = stuck_q;
`endif

endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
- Sequencer for one ring-oscillator instance.
- Enables the oscillator through its activate input and waits a settle interval.
- Counts rising edges of the oscillator output over a programmable window of `clk` cycles, then returns the count through a valid/ready handshake.
- Sits between the RO macro and the on-chip readout logic.

Parameters:
- GATE_W, 16, width of the gate-window length (clk cycles).
- CNT_W, 16, width of the edge counter and result.
- SETTLE_CYCLES, 4, clk cycles the RO runs before counting starts; must be at least 2.
- SYNC_STAGES, 2, flops in the `ro_in` synchronizer; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  measurement request; sampled only in IDLE.
- gate_cycles  in  GATE_W  window length; captured when `start` is accepted; 0 is treated as 1.
- abort  in  1  cancels the measurement in progress.
- ro_in  in  1  asynchronous oscillator output.
- ro_activate  out  1  drives the RO activate input.
- busy  out  1  high in every state except IDLE.
- result_count  out  CNT_W  edge count.
- result_sat  out  1  the counter saturated.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - ro_activate=0, busy=0, result_valid=0, result_count=0, result_sat=0.
  - Synchronizer flops, edge-detect flop, counters=0.
- Synchronizer: `ro_in` passes through SYNC_STAGES flops; the last stage feeds a delay flop. edge = sync & ~delayed.
- States:
  - IDLE: start=1 → capture gate_cycles (0→1), clear the counter and sat flag, go to SETTLE. start=0 → stay.
  - SETTLE: ro_activate=1. Runs exactly SETTLE_CYCLES cycles, then MEASURE. Edges in SETTLE are not counted.
  - MEASURE: ro_activate=1. Runs exactly gate_cycles cycles. Each cycle with edge=1 increments the counter. At max the counter holds and result_sat=1. After the last cycle go to DONE.
  - DONE: ro_activate=0, result_valid=1. result_count and result_sat are stable until the handshake. result_valid & result_ready → IDLE, result_valid=0 next cycle.
- Registered outputs: ro_activate, busy, result_valid and the result fields change on the clk edge of the state transition.
- Timing from start accepted at edge T:
  - ro_activate high from T+1 through T+SETTLE_CYCLES+gate_cycles.
  - result_valid high from T+SETTLE_CYCLES+gate_cycles+1.
- abort=1 in SETTLE or MEASURE:
  - Next state IDLE, ro_activate=0.
  - No result; result_valid stays 0, result fields keep their previous values.
  - abort has priority over normal transitions.
  - abort in IDLE or DONE is ignored.
- Other boundary conditions:
  - start while busy is ignored.
  - start in the same cycle as the DONE handshake is ignored; it is honoured the next cycle in IDLE.
  - gate_cycles changing after capture has no effect.
  - Reset mid-measurement behaves exactly as reset from IDLE.
  - result_ready while result_valid=0 has no effect.

Optional Feature:
- Macro RO_MEAS_CTRL_STUCK_EN.
- Defined:
  - Adds output `result_stuck` (1 bit), reset 0.
  - Set with result_valid when the final count = 0 (oscillator dead or held).
  - Cleared on the next accepted start.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package `ro_pkg`:
  - State enum: IDLE, SETTLE, MEASURE, DONE, 2-bit encoding.
  - Default width and SETTLE_CYCLES constants.
- One natural sub-module, `ro_edge_sync`: SYNC_STAGES synchronizer plus rising-edge pulse output, clk/rst_n only.
- The FSM and counters stay in `ro_meas_ctrl`.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, random inputs → all outputs 0, state IDLE, busy=0.
2. Bench ro_in toggles every 3 clk cycles (period 6), start with gate_cycles=60 → ro_activate high for exactly 64 cycles; result_valid at T+65; result_count in {9,10,11}; result_sat=0.
3. CNT_W=4, ro_in period 2 cycles, gate_cycles=100 → result_count=15, result_sat=1.
4. abort 10 cycles into MEASURE → next cycle ro_activate=0, busy=0, result_valid never asserts; a new start then completes normally.
5. Hold result_ready=0 for 20 cycles in DONE, pulse start meanwhile → result stable; start ignored; after the ready handshake, IDLE; a subsequent start is accepted.
6. gate_cycles=0, ro_in held 0 → 1-cycle window, result_count=0; with RO_MEAS_CTRL_STUCK_EN defined, result_stuck=1.
